wb_conbus_rr: RTL and testbench

WB_CONBUS_RR -- requirements
Module: wb_conbus_rr

---
 rtl/wb_conbus_rr.sv | 160 ++++++++++++++++
 tb/tb_wb_conbus_rr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_conbus_rr.sv
// Wishbone shared-bus interconnect: NM masters round-robin onto NS address-decoded slaves.
// state | meaning:  IDLE | no master granted;  BUSY | gnt/gidx own the bus until their cyc drops
module wb_conbus_rr #(
  parameter int NM = 2,
  parameter int NS = 6,
  parameter int S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0] S_ADDR = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NM*32-1:0]   m_adr_i,
  input  logic [NM*32-1:0]   m_dat_i,
  input  logic [NM*4-1:0]    m_sel_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  output logic [31:0]        m_dat_o,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_err_o,
  output logic [31:0]        s_adr_o,
  output logic [31:0]        s_dat_o,
  output logic [3:0]         s_sel_o,
  output logic               s_we_o,
  output logic [NS-1:0]      s_cyc_o,
  output logic [NS-1:0]      s_stb_o,
  input  logic [NS*32-1:0]   s_dat_i,
  input  logic [NS-1:0]      s_ack_i
);
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic          state;
  logic [NM-1:0] gnt;
  logic [IW-1:0] rr;
  logic [IW-1:0] gidx;
  logic [15:0]   wd_cnt;
  logic          err_r;
  logic          to_flag;

  logic          busy;
  logic          g_cyc, g_stb, g_we;
  logic [31:0]   g_adr, g_dat;
  logic [3:0]    g_sel;
  logic [IW-1:0] pick;
  logic [NS-1:0] ssel;
  logic          hit;
  logic [31:0]   sl_dat;
  logic          sl_ack;
  logic          live;
  logic          err_to;
  logic          err_g;

  assign busy  = (state == ST_BUSY);
  assign g_cyc = busy & m_cyc_i[gidx];
  assign g_stb = busy & m_stb_i[gidx];
  assign g_we  = busy & m_we_i[gidx];
  assign g_adr = busy ? m_adr_i[gidx*32 +: 32] : 32'h0;
  assign g_dat = busy ? m_dat_i[gidx*32 +: 32] : 32'h0;
  assign g_sel = busy ? m_sel_i[gidx*4 +: 4] : 4'h0;

  // First requester at or after rr, wrapping.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = rr;
    for (int o = 0; o < NM; o++) begin
      idx = (int'(rr) + o) % NM;
      if (!found && m_cyc_i[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ssel = '0;
    hit  = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (!hit && s_adr_o[31 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]) begin
        ssel[k] = 1'b1;
        hit     = 1'b1;
      end
    end
  end

  always_comb begin
    sl_dat = 32'h0;
    sl_ack = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (ssel[k]) begin
        sl_dat = s_dat_i[k*32 +: 32];
        sl_ack = s_ack_i[k];
      end
    end
  end

  // After a timeout the slave is cut off until the master gives up the cycle.
  assign live   = g_cyc & ~to_flag;
  assign err_to = live & g_stb & hit & ~sl_ack & (wd_cnt == 16'(TIMEOUT - 1));
  assign err_g  = busy & (err_r | err_to);

  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_sel_o = g_sel;
  assign s_we_o  = g_we;
  assign s_cyc_o = ssel & {NS{live}};
  assign s_stb_o = ssel & {NS{live & g_stb}};
  assign m_dat_o = (live & hit) ? sl_dat : 32'h0;
  assign m_err_o = gnt & {NM{err_g}};
  assign m_ack_o = gnt & {NM{live & hit & sl_ack & ~err_g}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      rr      <= '0;
      gidx    <= '0;
      wd_cnt  <= '0;
      err_r   <= 1'b0;
      to_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt  <= '0;
          err_r   <= 1'b0;
          to_flag <= 1'b0;
          if (|m_cyc_i) begin
            state <= ST_BUSY;
            gidx  <= pick;
            gnt   <= NM'(1) << pick;
          end
        end
        ST_BUSY: begin
          if (!m_cyc_i[gidx]) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            rr      <= (gidx == IW'(NM - 1)) ? '0 : gidx + 1'b1;
            wd_cnt  <= '0;
            err_r   <= 1'b0;
            to_flag <= 1'b0;
          end else begin
            // Unmapped access: one-clock error, then one quiet clock before it may repeat.
            err_r <= g_stb & ~hit & ~err_r & ~to_flag;
            if (err_to)
              to_flag <= 1'b1;
            if ((hit & sl_ack) | err_g)
              wd_cnt <= '0;
            else if (g_stb & ~to_flag)
              wd_cnt <= wd_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_conbus_rr.sv
// Bench for wb_conbus_rr: table-driven single transfers plus arbitration, timeout and reset sequences.
module tb_wb_conbus_rr;
  localparam int NM = 2;
  localparam int NS = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*32-1:0]  m_adr_i, m_dat_i;
  logic [NM*4-1:0]   m_sel_i;
  logic [NM-1:0]     m_we_i, m_cyc_i, m_stb_i;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic [NS*32-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i;

  wb_conbus_rr #(.NM(NM), .NS(NS), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    int          dly;
    logic [31:0] rdat;
    int          sl;
  } vec_t;
  vec_t vecs[8];

  task automatic expect_val(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = sb.pop_front();
      if (act === e.val) passes++;
      else $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
    end
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_m(input int j, input logic cyc, input logic [31:0] adr,
                       input logic we, input logic [31:0] dat);
    m_cyc_i[j]         = cyc;
    m_stb_i[j]         = cyc;
    m_adr_i[j*32 +: 32] = adr;
    m_we_i[j]          = we;
    m_dat_i[j*32 +: 32] = dat;
  endtask

  initial begin
    vec_t v;
    logic [31:0] one_m;
    logic [31:0] one_s;
    int g;

    vecs[0] = '{0, 32'h4000_0004, 1'b0, 32'h0,         1, 32'hA5A5_A5A5, 1};
    vecs[1] = '{1, 32'h0000_0010, 1'b1, 32'h1234_5678, 0, 32'h0,         0};
    vecs[2] = '{0, 32'hC000_0000, 1'b0, 32'h0,         2, 32'h5A5A_0F0F, 5};
    vecs[3] = '{1, 32'h8000_0100, 1'b0, 32'h0,         2, 32'h0BAD_F00D, 3};
    vecs[4] = '{1, 32'hE000_0000, 1'b0, 32'h0,         0, 32'h0,        -1};
    vecs[5] = '{0, 32'h2000_0004, 1'b0, 32'h0,         0, 32'h0,        -1};
    vecs[6] = '{0, 32'h6000_0000, 1'b1, 32'hCAFE_0006, 0, 32'h6666_6666, 2};
    vecs[7] = '{0, 32'hA000_0000, 1'b0, 32'h0,         1, 32'h4444_4444, 4};

    rst = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = {NM{4'hF}};
    m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    s_dat_i = '0; s_ack_i = '0;
    set_m(0, 1'b1, 32'h4000_0000, 1'b1, 32'h1111_1111);

    mid();
    expect_val("rst_s_cyc", 32'h0);  check(32'(s_cyc_o | s_stb_o));
    expect_val("rst_s_adr", 32'h0);  check(s_adr_o);
    expect_val("rst_ack_err", 32'h0); check(32'({m_ack_o, m_err_o}));
    expect_val("rst_s_dat_we", 32'h0); check(s_dat_o | 32'({s_sel_o, s_we_o}));
    cyc_start();
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc_start();
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      one_m = 32'(1) << v.m;
      one_s = (v.sl < 0) ? 32'h0 : (32'(1) << v.sl);
      cyc_start();
      set_m(v.m, 1'b1, v.adr, v.we, v.wdat);
      mid();
      expect_val("arb_latency_s_cyc", 32'h0); check(32'(s_cyc_o));
      if (v.sl >= 0) begin
        for (int d = 0; d <= v.dly; d++) begin
          cyc_start();
          if (d == v.dly) begin
            s_ack_i[v.sl] = 1'b1;
            s_dat_i[v.sl*32 +: 32] = v.rdat;
          end
          mid();
          if (d == 0) begin
            expect_val("dec_s_cyc", one_s);     check(32'(s_cyc_o));
            expect_val("dec_s_stb", one_s);     check(32'(s_stb_o));
            expect_val("pass_s_adr", v.adr);    check(s_adr_o);
            expect_val("pass_s_dat", v.wdat);   check(s_dat_o);
            expect_val("pass_s_we", 32'(v.we)); check(32'(s_we_o));
          end
          if (d == v.dly) begin
            expect_val("ack_m_ack", one_m);   check(32'(m_ack_o));
            expect_val("ack_m_dat", v.rdat);  check(m_dat_o);
            expect_val("ack_m_err", 32'h0);   check(32'(m_err_o));
          end
        end
        cyc_start();
        s_ack_i = '0;
        s_dat_i = '0;
        set_m(v.m, 1'b0, 32'h0, 1'b0, 32'h0);
        mid();
        expect_val("drop_s_cyc", 32'h0); check(32'(s_cyc_o));
      end else begin
        cyc_start();
        mid();
        expect_val("unmapped_s_cyc", 32'h0); check(32'(s_cyc_o));
        expect_val("unmapped_err_c1", 32'h0); check(32'(m_err_o));
        cyc_start();
        mid();
        expect_val("unmapped_err_c2", one_m); check(32'(m_err_o));
        expect_val("unmapped_ack_c2", 32'h0); check(32'(m_ack_o));
        cyc_start();
        mid();
        expect_val("unmapped_err_c3", 32'h0); check(32'(m_err_o));
        cyc_start();
        set_m(v.m, 1'b0, 32'h0, 1'b0, 32'h0);
      end
    end

    // Watchdog: slave3 never answers.
    cyc_start();
    set_m(0, 1'b1, 32'h8000_0000, 1'b0, 32'h0);
    for (int s = 1; s <= 4; s++) begin
      cyc_start();
      mid();
      expect_val($sformatf("to_err_stall%0d", s), (s == 4) ? 32'h1 : 32'h0); check(32'(m_err_o));
      expect_val($sformatf("to_s_cyc_stall%0d", s), 32'h8); check(32'(s_cyc_o));
    end
    cyc_start();
    s_ack_i[3] = 1'b1;
    s_dat_i[3*32 +: 32] = 32'hDEAD_BEEF;
    mid();
    expect_val("to_after_s_cyc", 32'h0); check(32'(s_cyc_o | s_stb_o));
    expect_val("to_late_ack", 32'h0);    check(32'({m_ack_o, m_err_o}));
    cyc_start();
    s_ack_i = '0;
    s_dat_i = '0;
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);

    // m1 drops cyc in the same cycle m0 raises it.
    cyc_start();
    set_m(1, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    cyc_start();
    mid();
    expect_val("sim_m1_adr", 32'h0000_0040); check(s_adr_o);
    cyc_start();
    set_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
    set_m(0, 1'b1, 32'h6000_0008, 1'b0, 32'h0);
    mid();
    expect_val("sim_drop_s_cyc", 32'h0); check(32'(s_cyc_o));
    cyc_start();
    mid();
    expect_val("sim_idle_s_cyc", 32'h0); check(32'(s_cyc_o));
    cyc_start();
    mid();
    expect_val("sim_m0_s_cyc", 32'h4); check(32'(s_cyc_o));
    expect_val("sim_m0_adr", 32'h6000_0008); check(s_adr_o);
    cyc_start();
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Asynchronous reset between edges while m1 owns the bus.
    cyc_start();
    set_m(1, 1'b1, 32'h8000_0000, 1'b0, 32'h0);
    cyc_start();
    mid();
    expect_val("ar_pre_s_cyc", 32'h8); check(32'(s_cyc_o));
    #2;
    rst = 1'b0;
    #1;
    expect_val("ar_s_cyc_stb", 32'h0); check(32'(s_cyc_o | s_stb_o));
    expect_val("ar_s_adr", 32'h0);     check(s_adr_o);
    set_m(0, 1'b1, 32'h4000_0000, 1'b0, 32'h0);
    set_m(1, 1'b1, 32'h4000_0100, 1'b0, 32'h0);
    cyc_start();
    cyc_start();
    rst = 1'b1;

    // Round robin: both masters keep requesting slave1, each leaves after one ack.
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      mid();
      expect_val($sformatf("rr%0d_idle_s_cyc", i), 32'h0); check(32'(s_cyc_o));
      cyc_start();
      s_ack_i[1] = 1'b1;
      s_dat_i[1*32 +: 32] = 32'h1000 + 32'(i);
      mid();
      expect_val($sformatf("rr%0d_ack", i), 32'(1) << g); check(32'(m_ack_o));
      expect_val($sformatf("rr%0d_adr", i), 32'h4000_0000 + 32'(g) * 32'h100); check(s_adr_o);
      cyc_start();
      s_ack_i = '0;
      s_dat_i = '0;
      m_cyc_i[g] = 1'b0;
      m_stb_i[g] = 1'b0;
      cyc_start();
      m_cyc_i[g] = 1'b1;
      m_stb_i[g] = 1'b1;
    end
    m_cyc_i = '0;
    m_stb_i = '0;
    cyc_start();
    cyc_start();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
